// File: rtl/proc_pkg.sv
// Shared opcode values, FSM state encoding and instruction-register field helpers
// for the processor control unit.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_MVNZ = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FWAIT, S_LDIR, S_T1, S_T2, S_TWAIT, S_T3
  } state_e;

  function automatic logic [2:0] ir_op(input logic [8:0] ir);
    return ir[8:6];
  endfunction

  function automatic logic [2:0] ir_rx(input logic [8:0] ir);
    return ir[5:3];
  endfunction

  function automatic logic [2:0] ir_ry(input logic [8:0] ir);
    return ir[2:0];
  endfunction

  // An instruction collapses to a NOP when any register it actually uses is out of range.
  function automatic logic ir_is_nop(input logic [8:0] ir, input logic [2:0] limit);
    logic use_x, use_y;
    use_x = (ir_op(ir) != OP_RSV);
    use_y = use_x && (ir_op(ir) != OP_MVI);
    return (use_x && (ir_rx(ir) >= limit)) || (use_y && (ir_ry(ir) >= limit));
  endfunction

endpackage

// File: rtl/proc_control_fsm_ctrl_wait_timer.sv
// Loadable down-counter used to hold the FSM in a memory wait state;
// wait_done is high during the last wait cycle.
module ctrl_wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       wait_done
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != 3'd0)
      cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 3'd0;
    else        cnt_q <= cnt_d;
  end

  assign wait_done = (cnt_q == 3'd1);

endmodule

// File: rtl/proc_control_fsm.sv
// Control unit of the simple processor: fetch/decode/execute sequencer whose
// datapath strobes are decoded from the current state and the IR fields.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned NREGS   = 7
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [8:0] IR,
  input  logic       Gnz,
  output logic       Rin_en,
  output logic [2:0] Rin_sel,
  output logic       Rout_en,
  output logic [2:0] Rout_sel,
  output logic       PCout,
  output logic       Gout,
  output logic       DINout,
  output logic       IRin,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       ADDRin,
  output logic       DOUTin,
  output logic       W_D,
  output logic       incr_pc,
  output logic       Done
);

  localparam logic [2:0] LAT       = 3'(MEM_LAT);
  localparam logic [2:0] REG_LIMIT = 3'(NREGS);

  state_e     state_q, state_d;
  logic       tmr_load, wait_done;
  logic [2:0] op, rx, ry;
  logic       nop;

  assign op  = ir_op(IR);
  assign rx  = ir_rx(IR);
  assign ry  = ir_ry(IR);
  assign nop = ir_is_nop(IR, REG_LIMIT);

  ctrl_wait_timer u_wait (
    .clk       (Clock),
    .rst_n     (Resetn),
    .load      (tmr_load),
    .load_val  (LAT),
    .wait_done (wait_done)
  );

  always_comb begin
    Rin_en = 1'b0; Rin_sel = 3'd0; Rout_en = 1'b0; Rout_sel = 3'd0;
    PCout = 1'b0; Gout = 1'b0; DINout = 1'b0; IRin = 1'b0;
    Ain = 1'b0; Gin = 1'b0; AddSub = 1'b0; ADDRin = 1'b0;
    DOUTin = 1'b0; W_D = 1'b0; incr_pc = 1'b0; Done = 1'b0;
    case (state_q)
      S_FETCH: begin PCout = 1'b1; ADDRin = 1'b1; end
      S_LDIR:  begin IRin = 1'b1; incr_pc = 1'b1; end
      S_T1: begin
        if (nop || op == OP_RSV || (op == OP_MVNZ && !Gnz)) begin
          Done = 1'b1;
        end else begin
          case (op)
            OP_MV, OP_MVNZ: begin
              Rout_en = 1'b1; Rout_sel = ry; Rin_en = 1'b1; Rin_sel = rx; Done = 1'b1;
            end
            OP_MVI:         begin PCout = 1'b1; ADDRin = 1'b1; end
            OP_ADD, OP_SUB: begin Rout_en = 1'b1; Rout_sel = rx; Ain = 1'b1; end
            OP_LD, OP_ST:   begin Rout_en = 1'b1; Rout_sel = ry; ADDRin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T2: begin
        if (op == OP_ST) begin
          Rout_en = 1'b1; Rout_sel = rx; DOUTin = 1'b1; W_D = 1'b1; Done = 1'b1;
        end else begin
          Rout_en = 1'b1; Rout_sel = ry; Gin = 1'b1; AddSub = op[0];
        end
      end
      S_T3: begin
        Rin_en  = 1'b1;
        Rin_sel = rx;
        Done    = 1'b1;
        incr_pc = (op == OP_MVI);
        if (op == OP_ADD || op == OP_SUB) Gout = 1'b1;
        else                              DINout = 1'b1;
      end
      default: ;
    endcase
    // Never write an out-of-range register even if IR changes mid-instruction.
    if (Rin_sel >= REG_LIMIT) begin
      Rin_en  = 1'b0;
      Rin_sel = 3'd0;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    case (state_q)
      S_IDLE:  if (Run) state_d = S_FETCH;
      S_FETCH: begin
        tmr_load = 1'b1;
        state_d  = (LAT == 3'd0) ? S_LDIR : S_FWAIT;
      end
      S_FWAIT: if (wait_done) state_d = S_LDIR;
      S_LDIR:  state_d = S_T1;
      S_T1: begin
        if (op == OP_MVI || op == OP_LD) begin
          tmr_load = 1'b1;
          state_d  = (LAT == 3'd0) ? S_T3 : S_TWAIT;
        end else begin
          state_d = S_T2;
        end
      end
      S_T2:    state_d = S_T3;
      S_TWAIT: if (wait_done) state_d = S_T3;
      default: state_d = S_IDLE;
    endcase
    if (Done) state_d = Run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

endmodule
